// File: rtl/ram_scan_pkg.sv
// rtl/ram_scan_pkg.sv - shared constants and address type for the 32x8 RAM scan counters
package ram_scan_pkg;
  localparam int RAM_AW    = 5;
  localparam int RAM_DEPTH = 32;
  localparam int P1_STEP   = 1;
  localparam int P2_STEP   = 4;

  typedef logic [RAM_AW-1:0] ram_addr_t;
endpackage

// File: rtl/counter1.sv
// rtl/counter1.sv - port-1 byte scan counter (step 1) on the fast clock
module counter1
  import ram_scan_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      en,
  output ram_addr_t count,
  output logic      last,
  output logic      wrap
);

  scan_counter #(
    .WIDTH (RAM_AW),
    .STEP  (P1_STEP)
  ) u_scan_counter (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .count (count),
    .last  (last),
    .wrap  (wrap)
  );

endmodule

// File: rtl/counter2.sv
// rtl/counter2.sv - port-2 4-byte scan counter (step 4) on the slow clock
module counter2
  import ram_scan_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      en,
  output ram_addr_t count,
  output logic      last,
  output logic      wrap
);

  scan_counter #(
    .WIDTH (RAM_AW),
    .STEP  (P2_STEP)
  ) u_scan_counter (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .count (count),
    .last  (last),
    .wrap  (wrap)
  );

endmodule

// File: rtl/scan_counter.sv
// rtl/scan_counter.sv - free-running modulo-2**WIDTH scan address counter advancing by STEP
module scan_counter
  import ram_scan_pkg::*;
#(
  parameter int WIDTH = RAM_AW,
  parameter int STEP  = P1_STEP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             last,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] STEP_V    = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] LAST_ADDR = WIDTH'((1 << WIDTH) - STEP);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             w_last;

  assign w_last = (r_count == LAST_ADDR);

  // Carry out of the add is dropped, so the final address rolls straight to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_wrap <= en & w_last;
      if (en) begin
        r_count <= r_count + STEP_V;
      end
    end
  end

  assign count = r_count;
  assign last  = w_last;
  assign wrap  = r_wrap;

endmodule

// File: tb/tb_scan_counter.sv
// tb/tb_scan_counter.sv - randomized self-checking bench for scan_counter and its two wrappers
module tb_scan_counter;

  logic       clk1, clk2, rst_n, en1, en2;
  logic [4:0] count1, count1w, count2;
  logic       last1, wrap1, last1w, wrap1w, last2, wrap2;

  bit clk_run = 1'b0;
  int ph      = 0;
  int total   = 0;
  int bad     = 0;

  // Reference state: plain integer addresses, wrap = "this edge landed on zero by counting".
  int m1 = 0;
  int m2 = 0;
  bit w1 = 1'b0;
  bit w2 = 1'b0;

  scan_counter #(.WIDTH(5), .STEP(1)) u_dut (
    .clk(clk1), .reset(rst_n), .en(en1), .count(count1), .last(last1), .wrap(wrap1)
  );

  counter1 u_c1 (
    .clk(clk1), .reset(rst_n), .en(en1), .count(count1w), .last(last1w), .wrap(wrap1w)
  );

  counter2 u_c2 (
    .clk(clk2), .reset(rst_n), .en(en2), .count(count2), .last(last2), .wrap(wrap2)
  );

  // Fast clock period 10; slow clock rises on every 4th fast rising edge.
  initial begin
    clk1 = 1'b0;
    clk2 = 1'b0;
    wait (clk_run);
    forever begin
      #5;
      clk1 = 1'b1;
      if (ph == 0) clk2 = 1'b1;
      else if (ph == 2) clk2 = 1'b0;
      ph = (ph + 1) % 4;
      #5;
      clk1 = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk1 or negedge rst_n);
      if (!rst_n) begin
        m1 = 0;
        w1 = 1'b0;
      end else begin
        w1 = en1 && (((m1 + 1) % 32) == 0);
        if (en1) m1 = (m1 + 1) % 32;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk2 or negedge rst_n);
      if (!rst_n) begin
        m2 = 0;
        w2 = 1'b0;
      end else begin
        w2 = en2 && (((m2 + 4) % 32) == 0);
        if (en2) m2 = (m2 + 4) % 32;
      end
    end
  end

  always @(posedge clk1) if (rst_n) assert (!$isunknown(en1)) else $error("en1 unknown");
  always @(posedge clk2) if (rst_n) assert (!$isunknown(en2)) else $error("en2 unknown");

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic check_all();
    chk("cnt1",   int'(count1),  m1);
    chk("last1",  int'(last1),   int'(m1 == 31));
    chk("wrap1",  int'(wrap1),   int'(w1));
    chk("cnt1w",  int'(count1w), m1);
    chk("last1w", int'(last1w),  int'(m1 == 31));
    chk("wrap1w", int'(wrap1w),  int'(w1));
    chk("cnt2",   int'(count2),  m2);
    chk("last2",  int'(last2),   int'(m2 == 28));
    chk("wrap2",  int'(wrap2),   int'(w2));
  endtask

  task automatic cyc();
    @(posedge clk1);
    #1;
    check_all();
  endtask

  task automatic cyc2();
    @(posedge clk2);
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    en1   = 1'b0;
    en2   = 1'b0;

    // reset with the clock idle
    #1;
    chk("t1_cnt1", int'(count1), 0);
    chk("t1_last1", int'(last1), 0);
    chk("t1_wrap1", int'(wrap1), 0);
    chk("t1_cnt2", int'(count2), 0);
    check_all();
    #2;
    rst_n   = 1'b1;
    clk_run = 1'b1;
    repeat (5) cyc();
    chk("t1_hold", int'(count1), 0);

    // full step-1 pass and wrap pulse
    en1 = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      cyc();
      chk("t2_seq", int'(count1), i);
    end
    chk("t2_last", int'(last1), 1);
    cyc();
    chk("t2_zero", int'(count1), 0);
    chk("t2_wrap", int'(wrap1), 1);
    en1 = 1'b0;
    cyc();
    chk("t2_wrap_gone", int'(wrap1), 0);

    // enable gaps resume from held value
    en1 = 1'b1;
    repeat (5) cyc();
    chk("t3_five", int'(count1), 5);
    en1 = 1'b0;
    repeat (3) cyc();
    chk("t3_held", int'(count1), 5);
    en1 = 1'b1;
    repeat (2) cyc();
    chk("t3_seven", int'(count1), 7);
    en1 = 1'b0;

    // step-4 pass on the slow clock
    en2 = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cyc2();
      chk("t4_seq", int'(count2), (4 * i) % 32);
      if (i == 7) chk("t4_last", int'(last2), 1);
      if (i == 8) chk("t4_wrap", int'(wrap2), 1);
    end
    en2 = 1'b0;
    cyc2();
    chk("t4_wrap_gone", int'(wrap2), 0);

    // asynchronous reset mid-pass
    en1 = 1'b1;
    repeat (10) cyc();
    chk("t5_at17", int'(count1), 17);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_cnt_rst", int'(count1), 0);
    check_all();
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk("t5_resume", int'(count1), i);
    end
    repeat (29) cyc();
    chk("t5_wrapped", int'(wrap1), 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_wrap_cancel", int'(wrap1), 0);
    rst_n = 1'b1;
    en1 = 1'b0;

    // RAM FSM: cycle until port-1 reaches its last address
    #3 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    for (int k = 0; k < 60; k++) begin
      en1 = (count1 < 5'd31);
      en2 = en1;
      cyc();
    end
    chk("t6_stop", int'(count1), 31);
    chk("t6_last", int'(last1), 1);
    chk("t6_en_off", int'(en1), 0);

    // random enables with occasional mid-cycle resets
    repeat (400) begin
      en1 = 1'($urandom_range(0, 1));
      en2 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0) begin
        #3 rst_n = 1'b0;
        #1;
        chk("rnd_rst", int'(count1), 0);
        check_all();
        rst_n = 1'b1;
      end
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
